// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus address default, FSM states and the
// condition bundle passed from the bus monitor to the protocol engines.
package i2c_pkg;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_IGNORE
    } i2c_state_e;

    typedef struct packed {
        logic sda;
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } i2c_bus_t;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA and flags SCL edges plus START/STOP conditions.
// Flags are registered one clk after the last synchroniser stage.
module i2c_bus_monitor
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     scl_i,
    input  logic     sda_i,
    output i2c_bus_t bus_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;
    i2c_bus_t               bus_q;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];
    assign bus_o = bus_q;

    // Synchroniser chain, previous-value flops and registered condition flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_sync_q     <= '1;
            sda_sync_q     <= '1;
            scl_prev_q     <= 1'b1;
            sda_prev_q     <= 1'b1;
            bus_q.sda      <= 1'b1;
            bus_q.scl_rise <= 1'b0;
            bus_q.scl_fall <= 1'b0;
            bus_q.start    <= 1'b0;
            bus_q.stop     <= 1'b0;
        end else begin
            scl_sync_q     <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q     <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q     <= scl_s;
            sda_prev_q     <= sda_s;
            bus_q.sda      <= sda_s;
            bus_q.scl_rise <= scl_s & ~scl_prev_q;
            bus_q.scl_fall <= ~scl_s & scl_prev_q;
            bus_q.start    <= scl_s & scl_prev_q & sda_prev_q & ~sda_s;
            bus_q.stop     <= scl_s & scl_prev_q & ~sda_prev_q & sda_s;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, byte write/read engines and ACK handling.
// SDA is only ever pulled low or released; updates follow an SCL fall.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = I2C_DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy
);

    i2c_bus_t   bus;
    i2c_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] txsh_q, txsh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic       oe_q, oe_d;
    logic       phase_q, phase_d;

    i2c_bus_monitor #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_mon (
        .clk  (clk),
        .rst  (rst),
        .scl_i(i2c_scl),
        .sda_i(i2c_sda),
        .bus_o(bus)
    );

    assign i2c_sda  = oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd7;
            shreg_q    <= 8'h00;
            txsh_q     <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            oe_q       <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            txsh_q     <= txsh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            oe_q       <= oe_d;
            phase_q    <= phase_d;
        end
    end

    // Next state: START/STOP override everything, then per-state SCL handling.
    // phase_q marks the second half of an ACK slot (drive done, await release).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        txsh_d     = tx_req_q ? tx_data : txsh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        oe_d       = oe_q;
        phase_d    = phase_q;
        if (bus.start || bus.stop) begin
            state_d = bus.start ? ST_ADDR : ST_IDLE;
            cnt_d   = 3'd7;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (bus.scl_rise) begin
                        shreg_d = {shreg_q[6:0], bus.sda};
                        if (cnt_q == 3'd0) begin
                            if (shreg_d[7:1] == TARGET_ADDR) begin
                                state_d  = ST_ADDR_ACK;
                                busy_d   = 1'b1;
                                tx_req_d = shreg_d[0];
                                phase_d  = 1'b0;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                ST_ADDR_ACK, ST_WRITE_ACK: begin
                    if (bus.scl_fall) begin
                        if (!phase_q) begin
                            oe_d    = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            cnt_d   = 3'd7;
                            if (state_q == ST_ADDR_ACK && shreg_q[0]) begin
                                state_d = ST_READ;
                                oe_d    = ~txsh_q[7];
                                txsh_d  = {txsh_q[6:0], 1'b0};
                            end else begin
                                state_d = ST_WRITE;
                                oe_d    = 1'b0;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.scl_rise) begin
                        shreg_d = {shreg_q[6:0], bus.sda};
                        if (cnt_q == 3'd0) begin
                            rx_data_d  = shreg_d;
                            rx_valid_d = 1'b1;
                            state_d    = ST_WRITE_ACK;
                            phase_d    = 1'b0;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                ST_READ: begin
                    if (bus.scl_fall) begin
                        if (cnt_q != 3'd0) begin
                            oe_d   = ~txsh_q[7];
                            txsh_d = {txsh_q[6:0], 1'b0};
                            cnt_d  = cnt_q - 3'd1;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = ST_READ_ACK;
                            phase_d = 1'b0;
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (bus.scl_rise && !phase_q) begin
                        if (!bus.sda) begin
                            tx_req_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end else if (bus.scl_fall && phase_q) begin
                        phase_d = 1'b0;
                        state_d = ST_READ;
                        cnt_d   = 3'd7;
                        oe_d    = ~txsh_q[7];
                        txsh_d  = {txsh_q[6:0], 1'b0};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h50, meaning the 7-bit bus address this block answers to.
REQ-002 Parameter SYNC_STAGES, default 2, meaning the synchroniser depth on SCL/SDA inputs (legal 2..3).
REQ-003 clk  input  1  system clock; all logic on its rising edge; SHALL be at least 8x the SCL rate.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 i2c_scl  input  1  bus clock from the controller.
REQ-006 i2c_sda  inout  1  bus data; this block drives only 0 or 'z', never 1.
REQ-007 tx_data  input  8  byte returned on a read transfer; sampled at tx_req.
REQ-008 rx_data  output  8  last byte written by the controller.
REQ-009 rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-010 tx_req  output  1  one-clk pulse requesting tx_data for the next read byte.
REQ-011 busy  output  1  high from address match until STOP/START/abort.

Function
REQ-012 SCL and SDA SHALL pass through SYNC_STAGES flops; all edge and condition detection uses the synchronised values, so detection latency is SYNC_STAGES+1 clk.
REQ-013 START = SDA falling while SCL high; STOP = SDA rising while SCL high; either SHALL be honoured in every state.
REQ-014 States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
REQ-015 IDLE: on START -> ADDR with bit counter = 7; STOP ignored.
REQ-016 ADDR: sample SDA on each SCL rise MSB-first into an 8-bit shift register; after the 8th rise compare bits[7:1] to TARGET_ADDR.
REQ-017 Match -> ADDR_ACK; mismatch -> IGNORE with SDA released.
REQ-018 ADDR_ACK: drive SDA low from the SCL fall after bit 8 until the next SCL fall; assert busy at the match decision.
REQ-019 After ADDR_ACK: R/W=0 -> WRITE; R/W=1 -> READ; a tx_req pulse SHALL be issued at the match decision and tx_data latched on the next clk.
REQ-020 WRITE: shift 8 bits on SCL rises; after the 8th, rx_data <= byte and rx_valid pulses once; -> WRITE_ACK (drive 0 for one SCL period as REQ-018) -> WRITE for the next byte.
REQ-021 READ: on each SCL fall drive SDA low when the current latched bit is 0, else release; MSB first; after 8 bits release SDA -> READ_ACK.
REQ-022 READ_ACK: sample SDA at the SCL rise; 0 (ACK) -> pulse tx_req, latch next byte, -> READ; 1 (NACK) -> IGNORE.
REQ-023 IGNORE: SDA released; leave only on START (-> ADDR) or STOP (-> IDLE).
REQ-024 Any STOP -> IDLE, SDA released, busy low, within SYNC_STAGES+2 clk.
REQ-025 Repeated START mid-transfer -> ADDR, counter reloaded to 7, busy deasserted until the next match; a partial byte SHALL NOT produce rx_valid.
REQ-026 SDA SHALL change only in the clk following a detected SCL fall, never while synchronised SCL is high (except via release on STOP/START).
REQ-027 START and an SCL edge detected in the same clk: START wins.

Reset
REQ-028 With rst low at a clk rise: state=IDLE, counter=7, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, SDA released, synchroniser flops=1.
REQ-029 Reset mid-transfer SHALL release SDA on the next clk and discard any partial byte; the block then waits for a new START.

Structure
REQ-030 State encodings and the TARGET_ADDR default SHALL live in a shared package, i2c_pkg, also used by the I2C controller.
REQ-031 The synchroniser plus START/STOP/SCL-edge detector SHALL be one sub-module, i2c_bus_monitor; the FSM and shifters stay in i2c_target.

Verification
REQ-032 Controller writes 8'hA5 to address 7'h50 -> ACK low on 9th SCL, rx_data=8'hA5, exactly one rx_valid pulse, busy low after STOP.
REQ-033 Controller reads from 7'h50, tx_data=8'h3C, master NACKs -> SDA bits 0,0,1,1,1,1,0,0 on SCL rises, one tx_req pulse, -> IGNORE then IDLE on STOP.
REQ-034 Address 7'h51 write -> SDA never driven low by target, no rx_valid, busy stays 0, controller sees NACK and issues STOP.
REQ-035 Write of 8'h12 then 8'h34 without STOP -> two rx_valid pulses, rx_data=8'h12 then 8'h34, two ACKs.
REQ-036 Repeated START after 4 data bits, then write 8'hFF to 7'h50 -> no rx_valid for the partial byte, rx_data=8'hFF.
REQ-037 rst low for 1 clk during READ bit 3 -> SDA released next clk, all outputs at reset values, next START/address accepted normally.
